// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer for the instruction ROM: Start/Done handshake,
// branch target LUT (absolute or PC-relative), and a saturating RUN cycle counter.
module fetch_pc_unit #(
  parameter int PC_W      = 12,
  parameter int LUT_IDX_W = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stall,
  input  logic                 i_branch_en,
  input  logic                 i_branch_rel,
  input  logic [LUT_IDX_W-1:0] i_branch_idx,
  input  logic                 i_halt,
  input  logic                 i_lut_wr_en,
  input  logic [LUT_IDX_W-1:0] i_lut_wr_idx,
  input  logic [PC_W-1:0]      i_lut_wr_data,
  output logic [PC_W-1:0]      o_inst_address,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_cycle_count
);

  // state  | meaning
  // S_IDLE | after reset, waiting for Start
  // S_RUN  | fetching; PC advances, stalls or branches; cycles counted
  // S_DONE | halted; PC and count frozen until Start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int LUT_N = 1 << LUT_IDX_W;

  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [PC_W-1:0]    r_lut [LUT_N];
  logic [PC_W-1:0]    w_lut_rd;

  // Read sees the registered array, so a same-cycle write is only visible next cycle.
  assign w_lut_rd  = r_lut[i_branch_idx];
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = RESET_PC;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_halt) begin
          w_state_nxt = S_DONE;
        end else if (i_stall) begin
          w_pc_nxt = r_pc;
        end else if (i_branch_en) begin
          // Relative offset is two's complement; the modular add handles negatives.
          w_pc_nxt = i_branch_rel ? (r_pc + w_lut_rd) : w_lut_rd;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = RESET_PC;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lut <= '{default: '0};
    end else if (i_lut_wr_en) begin
      r_lut[i_lut_wr_idx] <= i_lut_wr_data;
    end
  end

  assign o_inst_address = r_pc;
  assign o_running      = (r_state == S_RUN);
  assign o_done         = (r_state == S_DONE);
  assign o_cycle_count  = r_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; each task drives one scenario
// and checks the outputs one step after the rising edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_en, branch_rel, halt, lut_wr_en;
  logic [4:0]  branch_idx, lut_wr_idx;
  logic [11:0] lut_wr_data;
  logic [11:0] inst_address;
  logic        running, done;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_unit dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_stall        (stall),
    .i_branch_en    (branch_en),
    .i_branch_rel   (branch_rel),
    .i_branch_idx   (branch_idx),
    .i_halt         (halt),
    .i_lut_wr_en    (lut_wr_en),
    .i_lut_wr_idx   (lut_wr_idx),
    .i_lut_wr_data  (lut_wr_data),
    .o_inst_address (inst_address),
    .o_running      (running),
    .o_done         (done),
    .o_cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes one LUT entry during a stall cycle so the PC does not move.
  task automatic lut_write(input logic [4:0] idx, input logic [11:0] data);
    stall = 1'b1; lut_wr_en = 1'b1; lut_wr_idx = idx; lut_wr_data = data;
    tick();
    stall = 1'b0; lut_wr_en = 1'b0;
  endtask

  task automatic branch(input logic rel, input logic [4:0] idx);
    branch_en = 1'b1; branch_rel = rel; branch_idx = idx;
    tick();
    branch_en = 1'b0; branch_rel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (inst_address !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want %h", inst_address, 12'h000); end
    n_cmp++; if ({running, done} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {running, done}); end
    n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    tick();
    n_cmp++; if ({running, inst_address} !== {1'b0, 12'h000}) begin n_err++; $display("FAIL idle_hold got run=%b pc=%h want run=0 pc=000", running, inst_address); end
  endtask

  task automatic test_free_run();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if ({running, done, inst_address} !== {2'b10, 12'h000}) begin n_err++; $display("FAIL start_enter got r=%b d=%b pc=%h want r=1 d=0 pc=000", running, done, inst_address); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (inst_address !== 12'(i)) begin n_err++; $display("FAIL free_run_pc[%0d] got %h want %h", i, inst_address, 12'(i)); end
    end
    n_cmp++; if (cycle_count !== 16'd5) begin n_err++; $display("FAIL free_run_count got %0d want 5", cycle_count); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL free_run_running got %b want 1", running); end
  endtask

  task automatic test_abs_branch();
    lut_write(5'd3, 12'h040);
    lut_write(5'd5, 12'h002);
    branch(1'b0, 5'd5);
    n_cmp++; if (inst_address !== 12'h002) begin n_err++; $display("FAIL abs_to_002 got %h want 002", inst_address); end
    branch(1'b0, 5'd3);
    n_cmp++; if (inst_address !== 12'h040) begin n_err++; $display("FAIL abs_to_040 got %h want 040", inst_address); end
  endtask

  task automatic test_rel_branch();
    lut_write(5'd6, 12'h010);
    lut_write(5'd4, 12'hFFE);
    lut_write(5'd7, 12'hFFD);
    branch(1'b0, 5'd6);
    n_cmp++; if (inst_address !== 12'h010) begin n_err++; $display("FAIL abs_to_010 got %h want 010", inst_address); end
    branch(1'b1, 5'd4);
    n_cmp++; if (inst_address !== 12'h00E) begin n_err++; $display("FAIL rel_minus2 got %h want 00E", inst_address); end
    lut_write(5'd4, 12'h005);
    branch(1'b0, 5'd7);
    n_cmp++; if (inst_address !== 12'hFFD) begin n_err++; $display("FAIL abs_to_FFD got %h want FFD", inst_address); end
    branch(1'b1, 5'd4);
    n_cmp++; if (inst_address !== 12'h002) begin n_err++; $display("FAIL rel_wrap got %h want 002", inst_address); end
  endtask

  task automatic test_wrap_priority();
    lut_write(5'd8, 12'hFFF);
    branch(1'b0, 5'd8);
    n_cmp++; if (inst_address !== 12'hFFF) begin n_err++; $display("FAIL abs_to_FFF got %h want FFF", inst_address); end
    tick();
    n_cmp++; if (inst_address !== 12'h000) begin n_err++; $display("FAIL pc_wrap got %h want 000", inst_address); end
    stall = 1'b1; branch(1'b0, 5'd8); stall = 1'b0;
    n_cmp++; if (inst_address !== 12'h000) begin n_err++; $display("FAIL stall_over_branch got %h want 000", inst_address); end
    halt = 1'b1; branch(1'b0, 5'd8); halt = 1'b0;
    n_cmp++; if ({running, done, inst_address} !== {2'b01, 12'h000}) begin n_err++; $display("FAIL halt_over_branch got r=%b d=%b pc=%h want r=0 d=1 pc=000", running, done, inst_address); end
  endtask

  task automatic test_halt_restart();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if ({running, done, inst_address, cycle_count} !== {2'b10, 12'h000, 16'd0}) begin n_err++; $display("FAIL restart got r=%b d=%b pc=%h cnt=%0d want r=1 d=0 pc=000 cnt=0", running, done, inst_address, cycle_count); end
    repeat (7) tick();
    n_cmp++; if ({inst_address, cycle_count} !== {12'h007, 16'd7}) begin n_err++; $display("FAIL pre_halt got pc=%h cnt=%0d want pc=007 cnt=7", inst_address, cycle_count); end
    halt = 1'b1; tick(); halt = 1'b0;
    n_cmp++; if ({running, done, inst_address, cycle_count} !== {2'b01, 12'h007, 16'd8}) begin n_err++; $display("FAIL halt got r=%b d=%b pc=%h cnt=%0d want r=0 d=1 pc=007 cnt=8", running, done, inst_address, cycle_count); end
    stall = 1'b0; branch_en = 1'b1; branch_idx = 5'd3;
    repeat (3) tick();
    branch_en = 1'b0;
    n_cmp++; if ({done, inst_address, cycle_count} !== {1'b1, 12'h007, 16'd8}) begin n_err++; $display("FAIL done_frozen got d=%b pc=%h cnt=%0d want d=1 pc=007 cnt=8", done, inst_address, cycle_count); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if ({running, done, inst_address, cycle_count} !== {2'b10, 12'h000, 16'd0}) begin n_err++; $display("FAIL done_restart got r=%b d=%b pc=%h cnt=%0d want r=1 d=0 pc=000 cnt=0", running, done, inst_address, cycle_count); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (inst_address !== 12'h001) begin n_err++; $display("FAIL start_ignored_in_run got %h want 001", inst_address); end
  endtask

  task automatic test_reset_mid_run();
    lut_write(5'd9, 12'h023);
    branch(1'b0, 5'd9);
    n_cmp++; if (inst_address !== 12'h023) begin n_err++; $display("FAIL abs_to_023 got %h want 023", inst_address); end
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    n_cmp++; if ({running, done, inst_address, cycle_count} !== {2'b00, 12'h000, 16'd0}) begin n_err++; $display("FAIL reset_mid_run got r=%b d=%b pc=%h cnt=%0d want all zero", running, done, inst_address, cycle_count); end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    branch(1'b0, 5'd9);
    n_cmp++; if (inst_address !== 12'h000) begin n_err++; $display("FAIL lut_cleared got %h want 000", inst_address); end
  endtask

  task automatic test_same_cycle_lut();
    lut_write(5'd1, 12'h030);
    lut_wr_en = 1'b1; lut_wr_idx = 5'd1; lut_wr_data = 12'h050;
    branch(1'b0, 5'd1);
    lut_wr_en = 1'b0;
    n_cmp++; if (inst_address !== 12'h030) begin n_err++; $display("FAIL same_cycle_old got %h want 030", inst_address); end
    branch(1'b0, 5'd1);
    n_cmp++; if (inst_address !== 12'h050) begin n_err++; $display("FAIL next_cycle_new got %h want 050", inst_address); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_rel = 1'b0;
    branch_idx = '0; halt = 1'b0; lut_wr_en = 1'b0; lut_wr_idx = '0; lut_wr_data = '0;
    test_reset();
    test_free_run();
    test_abs_branch();
    test_rel_branch();
    test_wrap_priority();
    test_halt_restart();
    test_reset_mid_run();
    test_same_cycle_lut();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
